// File: rtl/output_packet_streamer_pkg.sv
// Shared types and constants for the output packet streamer.
package output_packet_streamer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int HDR_WORDS  = 6;
    localparam int BRAM_DEPTH = 512;
    localparam int NUM_BRAMS  = 8;
    localparam int SEL_W      = $clog2(NUM_BRAMS);
    localparam int ADDR_W     = $clog2(BRAM_DEPTH);

    localparam logic [15:0] MAGIC_NOTIFY = 16'hC0DE;
    localparam logic [15:0] MAGIC_DATA   = 16'hDA7A;

endpackage

// File: rtl/output_packet_streamer_if.sv
// AXI-Stream style link from the streamer to the PS.
interface output_packet_streamer_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/output_packet_streamer_fifo.sv
// Small synchronous FIFO buffering header and payload words ahead of the stream.
module sync_fifo_small #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // storage array, written on push; contents are don't-care until counted
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/output_packet_streamer.sv
// Streams a 6-word header plus an optional multi-BRAM payload to the PS.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for send_header
//   HDR     | pushing latched header words 0..5 into the FIFO
//   DATA    | issuing BRAM reads, sel outer loop, addr inner loop
//   DRAIN   | all words queued; waiting for the tlast beat to transfer
//   DONE    | read_done pulse, back to IDLE next cycle
module output_packet_streamer
    import output_packet_streamer_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       header_word_0,
    input  logic [15:0]       header_word_1,
    input  logic [15:0]       header_word_2,
    input  logic [15:0]       header_word_3,
    input  logic [15:0]       header_word_4,
    input  logic [15:0]       header_word_5,
    input  logic              send_header,
    input  logic              trigger_read,
    input  logic [SEL_W-1:0]  rd_bram_start,
    input  logic [SEL_W-1:0]  rd_bram_end,
    input  logic [15:0]       rd_addr_count,
    output logic              bram_rd_en,
    output logic [SEL_W-1:0]  bram_rd_sel,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DW-1:0]     bram_rd_data,
    output_packet_streamer_if.master m_axis,
    output logic              read_done,
    output logic              busy,
    output logic              cmd_dropped,
    output logic              cfg_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [15:0]       hdr_q [HDR_WORDS];
    logic [2:0]        hdr_idx;
    logic              payload_q;
    logic [SEL_W-1:0]  cur_sel;
    logic [SEL_W-1:0]  sel_end;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_last;
    logic              in_flight;
    logic [15:0]       beat_cnt;
    logic [15:0]       last_beat;

    logic [CW-1:0]     fifo_count;
    logic [DW-1:0]     fifo_head;
    logic [CW-1:0]     occ;
    logic              hdr_push;
    logic              push;
    logic [DW-1:0]     push_data;
    logic              pop;
    logic              tvalid_int;
    logic              tlast_int;
    logic [15:0]       hdr_word;

    logic [ADDR_W:0]   cnt_clamped;
    logic              range_bad;
    logic              payload_ok;
    logic [SEL_W:0]    nsel;
    logic [15:0]       payload_beats;
    logic [15:0]       start_last_beat;

    // command decode evaluated on the start cycle only
    always_comb begin
        cnt_clamped     = (rd_addr_count > 16'(BRAM_DEPTH)) ? (ADDR_W+1)'(BRAM_DEPTH)
                                                           : rd_addr_count[ADDR_W:0];
        range_bad       = rd_bram_start > rd_bram_end;
        payload_ok      = trigger_read && (cnt_clamped != '0) && !range_bad;
        nsel            = {1'b0, rd_bram_end} - {1'b0, rd_bram_start} + (SEL_W+1)'(1);
        payload_beats   = 16'(nsel) * 16'(cnt_clamped);
        start_last_beat = 16'(HDR_WORDS - 1) + (payload_ok ? payload_beats : 16'd0);
    end

    // header word selected for the next HDR push
    always_comb begin
        hdr_word = '0;
        case (hdr_idx)
            3'd0:    hdr_word = hdr_q[0];
            3'd1:    hdr_word = hdr_q[1];
            3'd2:    hdr_word = hdr_q[2];
            3'd3:    hdr_word = hdr_q[3];
            3'd4:    hdr_word = hdr_q[4];
            3'd5:    hdr_word = hdr_q[5];
            default: hdr_word = '0;
        endcase
    end

    // a read may only issue if its returning word is guaranteed a FIFO slot
    assign occ        = fifo_count + CW'(in_flight);
    assign bram_rd_en = (state == S_DATA) && (occ < CW'(FIFO_DEPTH));
    assign bram_rd_sel  = cur_sel;
    assign bram_rd_addr = cur_addr;

    assign hdr_push  = (state == S_HDR) && (fifo_count < CW'(FIFO_DEPTH));
    assign push      = hdr_push || in_flight;
    assign push_data = in_flight ? bram_rd_data : DW'(hdr_word);

    assign tvalid_int    = (fifo_count != '0);
    assign tlast_int     = tvalid_int && (beat_cnt == last_beat);
    assign pop           = tvalid_int && m_axis.tready;
    assign m_axis.tvalid = tvalid_int;
    assign m_axis.tlast  = tlast_int;
    assign m_axis.tdata  = tvalid_int ? fifo_head : '0;

    sync_fifo_small #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // packet FSM, read sequencer and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            hdr_idx     <= '0;
            payload_q   <= 1'b0;
            cur_sel     <= '0;
            sel_end     <= '0;
            cur_addr    <= '0;
            addr_last   <= '0;
            in_flight   <= 1'b0;
            beat_cnt    <= '0;
            last_beat   <= '0;
            read_done   <= 1'b0;
            busy        <= 1'b0;
            cmd_dropped <= 1'b0;
            cfg_err     <= 1'b0;
            for (int i = 0; i < HDR_WORDS; i++) hdr_q[i] <= '0;
        end else begin
            read_done   <= 1'b0;
            cfg_err     <= 1'b0;
            cmd_dropped <= send_header && (state != S_IDLE);
            in_flight   <= bram_rd_en;
            if (pop) beat_cnt <= beat_cnt + 16'd1;

            case (state)
                S_IDLE: begin
                    if (send_header) begin
                        hdr_q[0]  <= header_word_0;
                        hdr_q[1]  <= header_word_1;
                        hdr_q[2]  <= header_word_2;
                        hdr_q[3]  <= header_word_3;
                        hdr_q[4]  <= header_word_4;
                        hdr_q[5]  <= header_word_5;
                        payload_q <= payload_ok;
                        cur_sel   <= rd_bram_start;
                        sel_end   <= rd_bram_end;
                        cur_addr  <= '0;
                        addr_last <= ADDR_W'(cnt_clamped - (ADDR_W+1)'(1));
                        last_beat <= start_last_beat;
                        beat_cnt  <= '0;
                        hdr_idx   <= '0;
                        cfg_err   <= range_bad;
                        busy      <= 1'b1;
                        state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (hdr_push) begin
                        if (hdr_idx == 3'(HDR_WORDS - 1)) begin
                            state <= payload_q ? S_DATA : S_DRAIN;
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (bram_rd_en) begin
                        if (cur_addr == addr_last) begin
                            cur_addr <= '0;
                            if (cur_sel == sel_end) begin
                                state <= S_DRAIN;
                            end else begin
                                cur_sel <= cur_sel + 1'b1;
                            end
                        end else begin
                            cur_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && tlast_int) begin
                        read_done <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_output_packet_streamer.sv
// Directed bench for output_packet_streamer: BRAM model, stream sink, beat scoreboard.
module tb_output_packet_streamer;
    import output_packet_streamer_pkg::*;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] hw [6];
    logic        send_header = 1'b0;
    logic        trigger_read = 1'b0;
    logic [2:0]  rd_bram_start = '0;
    logic [2:0]  rd_bram_end = '0;
    logic [15:0] rd_addr_count = '0;
    logic        bram_rd_en;
    logic [2:0]  bram_rd_sel;
    logic [8:0]  bram_rd_addr;
    logic [DW-1:0] bram_rd_data = '0;
    logic        read_done, busy, cmd_dropped, cfg_err;

    output_packet_streamer_if #(.DW(DW)) ax ();

    output_packet_streamer #(.DW(DW), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .header_word_0 (hw[0]),
        .header_word_1 (hw[1]),
        .header_word_2 (hw[2]),
        .header_word_3 (hw[3]),
        .header_word_4 (hw[4]),
        .header_word_5 (hw[5]),
        .send_header   (send_header),
        .trigger_read  (trigger_read),
        .rd_bram_start (rd_bram_start),
        .rd_bram_end   (rd_bram_end),
        .rd_addr_count (rd_addr_count),
        .bram_rd_en    (bram_rd_en),
        .bram_rd_sel   (bram_rd_sel),
        .bram_rd_addr  (bram_rd_addr),
        .bram_rd_data  (bram_rd_data),
        .m_axis        (ax),
        .read_done     (read_done),
        .busy          (busy),
        .cmd_dropped   (cmd_dropped),
        .cfg_err       (cfg_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bram_word(input int sel, input int addr);
        return {4'h8, 3'(sel), 9'(addr)};
    endfunction

    // BRAM model: data appears the cycle after the read request
    always @(posedge clk) begin
        if (bram_rd_en) bram_rd_data <= bram_word(int'(bram_rd_sel), int'(bram_rd_addr));
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [16:0] cap [$];
    logic [16:0] exp_q [$];
    int n_done, n_drop, n_cfg, n_rd, last_cyc, done_cyc;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_word = '0;

    // sink monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (ax.tvalid && ax.tready) begin
            cap.push_back({ax.tlast, ax.tdata});
            if (ax.tlast) last_cyc = cyc_cnt;
        end
        if (prev_stall && ax.tvalid && !rst)
            chk("hold_stable", 32'({ax.tlast, ax.tdata}), 32'(prev_word));
        prev_stall = ax.tvalid && !ax.tready;
        prev_word  = {ax.tlast, ax.tdata};
        if (read_done) begin n_done++; done_cyc = cyc_cnt; end
        if (cmd_dropped) n_drop++;
        if (cfg_err) n_cfg++;
        if (bram_rd_en) n_rd++;
    end

    logic [15:0] hdr_cfg [6];

    task automatic clear_stats();
        cap.delete();
        n_done = 0; n_drop = 0; n_cfg = 0; n_rd = 0;
        last_cyc = -100; done_cyc = 0;
    endtask

    task automatic drive_cmd(input logic trig, input logic [2:0] s, input logic [2:0] e,
                             input logic [15:0] cnt);
        for (int i = 0; i < 6; i++) hw[i] = hdr_cfg[i];
        trigger_read = trig; rd_bram_start = s; rd_bram_end = e; rd_addr_count = cnt;
        send_header = 1'b1;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 6; i++) hw[i] = 16'($urandom);
        trigger_read  = ~trigger_read;
        rd_bram_start = 3'($urandom);
        rd_bram_end   = 3'($urandom);
        rd_addr_count = 16'($urandom);
    endtask

    task automatic run_pkt(input string tag, input logic trig, input logic [2:0] s,
                           input logic [2:0] e, input logic [15:0] cnt,
                           input int mode, input int drop_at);
        int cl, nexp_rd, cyc, nbad, fb;
        bit pay, dropped;
        logic [16:0] t;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, hdr_cfg[i]});
        cl  = (cnt > 16'd512) ? 512 : int'(cnt);
        pay = trig && (cl != 0) && (s <= e);
        nexp_rd = 0;
        if (pay) begin
            for (int sl = int'(s); sl <= int'(e); sl++)
                for (int a = 0; a < cl; a++) begin
                    exp_q.push_back({1'b0, bram_word(sl, a)});
                    nexp_rd++;
                end
        end
        t = exp_q.pop_back(); t[16] = 1'b1; exp_q.push_back(t);

        clear_stats();
        @(posedge clk); #1;
        drive_cmd(trig, s, e, cnt);
        cyc = 0; dropped = 0;
        while (n_done == 0 && cyc < 20000) begin
            @(posedge clk); #1;
            send_header = 1'b0;
            if (cyc == 0) begin
                scramble_inputs();
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end
            case (mode)
                0:       ax.tready = 1'b1;
                1:       ax.tready = 1'($urandom_range(0, 1));
                2:       ax.tready = (cyc % 3) != 0;
                default: ax.tready = (cyc % 4) == 0;
            endcase
            if (drop_at >= 0 && !dropped && cap.size() >= drop_at) begin
                send_header = 1'b1;
                dropped = 1;
            end
            cyc++;
        end
        send_header = 1'b0;
        ax.tready = 1'b1;
        chk({tag, "_timeout"}, 32'(cyc < 20000), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_beats"}, 32'(cap.size()), 32'(exp_q.size()));
        nbad = 0; fb = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            if (cap[i] !== exp_q[i]) begin
                nbad++;
                if (fb < 0) fb = i;
            end
        end
        chk({tag, "_bad_beats"}, 32'(nbad), 32'd0);
        if (fb >= 0) chk({tag, "_first_bad"}, 32'(cap[fb]), 32'(exp_q[fb]));
        chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        chk({tag, "_done_lat"}, 32'(done_cyc - last_cyc), 32'd1);
        chk({tag, "_rd_cnt"}, 32'(n_rd), 32'(nexp_rd));
        chk({tag, "_cfg_err"}, 32'(n_cfg), 32'(s > e));
        chk({tag, "_dropped"}, 32'(n_drop), 32'(drop_at >= 0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 6; i++) hw[i] = '0;
        ax.tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(ax.tvalid), 32'd0);
        chk("rst_tlast", 32'(ax.tlast), 32'd0);
        chk("rst_tdata", 32'(ax.tdata), 32'd0);
        chk("rst_rd_en", 32'(bram_rd_en), 32'd0);
        chk("rst_sel", 32'(bram_rd_sel), 32'd0);
        chk("rst_addr", 32'(bram_rd_addr), 32'd0);
        chk("rst_done", 32'(read_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(cmd_dropped), 32'd0);
        chk("rst_cfg", 32'(cfg_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        hdr_cfg = '{MAGIC_NOTIFY, 16'h0001, 16'h0000, 16'h0000, 16'h0200, 16'h1234};
        run_pkt("notify", 1'b1, 3'd0, 3'd0, 16'd512, 0, -1);

        hdr_cfg = '{MAGIC_DATA, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'd1000};
        run_pkt("hdr_only", 1'b0, 3'd0, 3'd0, 16'd5, 0, -1);

        hdr_cfg = '{MAGIC_DATA, 16'h0003, 16'h0005, 16'h0002, 16'h0004, 16'hBEEF};
        run_pkt("cfg_err", 1'b1, 3'd5, 3'd2, 16'd4, 2, -1);

        hdr_cfg = '{MAGIC_DATA, 16'h0004, 16'h0006, 16'h0007, 16'd600, 16'h0A0A};
        run_pkt("clamp600", 1'b1, 3'd6, 3'd7, 16'd600, 1, -1);

        hdr_cfg = '{MAGIC_DATA, 16'h0005, 16'h0001, 16'h0001, 16'h0000, 16'h5555};
        run_pkt("cnt_zero", 1'b1, 3'd1, 3'd1, 16'd0, 0, -1);

        hdr_cfg = '{MAGIC_DATA, 16'h0006, 16'h0001, 16'h0002, 16'd20, 16'h6666};
        run_pkt("drop", 1'b1, 3'd1, 3'd2, 16'd20, 1, 10);

        hdr_cfg = '{MAGIC_DATA, 16'h0007, 16'h0003, 16'h0003, 16'd9, 16'h7777};
        run_pkt("slow_rdy", 1'b1, 3'd3, 3'd3, 16'd9, 3, -1);

        // abort mid-packet with reset near beat 100
        hdr_cfg = '{MAGIC_DATA, 16'h0008, 16'h0000, 16'h0001, 16'd100, 16'h8888};
        clear_stats();
        @(posedge clk); #1;
        drive_cmd(1'b1, 3'd0, 3'd1, 16'd100);
        @(posedge clk); #1;
        send_header = 1'b0;
        cyc = 0;
        while (cap.size() < 100 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach", 32'(cyc < 2000), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tvalid", 32'(ax.tvalid), 32'd0);
        chk("abort_tdata", 32'(ax.tdata), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(bram_rd_en), 32'd0);
        @(negedge clk);
        chk("abort_discard", 32'(ax.tvalid), 32'd0);
        repeat (20) @(posedge clk);
        chk("abort_no_done", 32'(n_done), 32'd0);
        #1;

        hdr_cfg = '{MAGIC_DATA, 16'h0009, 16'h0002, 16'h0004, 16'd33, 16'h9999};
        run_pkt("post_abort", 1'b1, 3'd2, 3'd4, 16'd33, 2, -1);

        hdr_cfg = '{MAGIC_DATA, 16'h000A, 16'h0000, 16'h0007, 16'd512, 16'hFFFF};
        run_pkt("full", 1'b1, 3'd0, 3'd7, 16'd512, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_packet_streamer.md
OUTPUT_PACKET_STREAMER -- requirements
Module: output_packet_streamer

Interface
REQ-001 Parameter DW, default 16: data/header word width on BRAM and stream.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries (power of 2, >=3).
REQ-003 clk  in  1  sole clock, all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 header_word_0..header_word_5  in  16 each  packet header, sampled on start.
REQ-006 send_header  in  1  start pulse; begins one packet.
REQ-007 trigger_read  in  1  sampled with send_header; 1 = append BRAM payload.
REQ-008 rd_bram_start, rd_bram_end  in  3 each  inclusive BRAM range.
REQ-009 rd_addr_count  in  16  words read per BRAM.
REQ-010 bram_rd_en  out  1; bram_rd_sel  out  3; bram_rd_addr  out  9  BRAM read request.
REQ-011 bram_rd_data  in  DW  read data, valid exactly 1 cycle after bram_rd_en.
REQ-012 m_axis_tdata  out  DW; m_axis_tvalid  out  1; m_axis_tlast  out  1; m_axis_tready  in  1  AXI-Stream master to PS.
REQ-013 read_done  out  1  one-cycle pulse, packet fully accepted.
REQ-014 busy  out  1; cmd_dropped  out  1 (pulse); cfg_err  out  1 (pulse).

Function
REQ-015 States IDLE, HDR, DATA, DRAIN, DONE; IDLE->HDR on send_header.
REQ-016 On start, latch all six header words, trigger_read, range and count; inputs are ignored afterwards.
REQ-017 HDR pushes header words 0..5 in order into the FIFO, one per cycle while the FIFO has space; after word 5, go to DATA if payload is non-empty, otherwise DRAIN.
REQ-018 Payload is empty when trigger_read=0, rd_addr_count=0, or rd_bram_start>rd_bram_end; the start>end case also pulses cfg_err on the start cycle.
REQ-019 rd_addr_count>512 is clamped to 512.
REQ-020 DATA issues reads for sel=start..end, with addr=0..count-1 per sel, addr fastest; one read per cycle at most.
REQ-021 A read issues only when fifo_count + in_flight < FIFO_DEPTH (in_flight = 0 or 1); bram_rd_data is pushed into the FIFO unconditionally the cycle after.
REQ-022 After the last read issues, go to DRAIN.
REQ-023 Stream output is driven from the FIFO head, tvalid = FIFO non-empty; a beat transfers when tvalid&tready.
REQ-024 tdata and tlast are held stable while tvalid&!tready.
REQ-025 tlast=1 only on the final beat: header word 5 for header-only packets, otherwise the last payload word.
REQ-026 Total beats = 6 + (end-start+1)*count; max 4102; beat counter is 16 bits.
REQ-027 DRAIN -> DONE the cycle after the tlast beat transfers.
REQ-028 DONE asserts read_done for 1 cycle, then returns to IDLE; a new send_header is accepted in the cycle following DONE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 send_header while busy: command ignored, cmd_dropped pulses 1 cycle, and the current packet is unaffected.
REQ-031 Simultaneous tready and FIFO push: push and pop occur in the same cycle, and count is unchanged.
REQ-032 No data beats are lost or duplicated under any tready pattern.

Reset
REQ-033 On rst: state=IDLE; FIFO empty; in_flight=0; counters=0.
REQ-034 On rst, these outputs are 0 the next cycle: tvalid, tlast, tdata, bram_rd_en, sel, addr, read_done, busy, cmd_dropped, cfg_err.
REQ-035 Reset mid-packet aborts the packet without read_done; BRAM data returning the cycle after reset is discarded.

Structure
REQ-036 Shared package holds the state encoding, HDR_WORDS=6, BRAM_DEPTH=512, NUM_BRAMS=8, and packet magic constants 16'hC0DE and 16'hDA7A.
REQ-037 One sub-module, sync_fifo_small (DW wide, FIFO_DEPTH deep, push/pop/count, same clk/rst); FSM and read sequencer live in the top module.

Verification
REQ-038 Notification packet: start=end=0, count=512, tready=1 -> 518 beats (6 header words then BRAM0 addr 0..511), tlast on beat 518, read_done 1 cycle after.
REQ-039 Full-data packet: start=0, end=7, count=512, tready random 50% -> 4102 beats, in order (sel, addr), none lost, tlast only on beat 4102.
REQ-040 trigger_read=0 with header {DA7A,0002,3,0,0,1000} -> exactly 6 beats, tlast on 1000, no bram_rd_en.
REQ-041 start=5, end=2 -> cfg_err pulse, 6-beat header-only packet; count=600 -> 512 words per BRAM.
REQ-042 send_header during a packet -> cmd_dropped pulse, original beat count unchanged; rst at beat 100 -> tvalid=0 next cycle, no read_done, new packet then completes correctly.
